// File: rtl/m_mem_arbiter_rr_pkg.sv
// Shared types and widths for the multi-hart memory-port arbiter.
// Every arbiter file imports this package.
package m_mem_arbiter_rr_pkg;

  // Debug-visible arbiter state encoding; 2'd3 is unreachable and treated as idle.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OWN      = 2'd1,
    ST_HANDOVER = 2'd2
  } arb_state_e;

  localparam int XLEN  = 32;
  localparam int CTRLW = 3;

  function automatic int sel_width(input int n_harts);
    return (n_harts > 1) ? $clog2(n_harts) : 1;
  endfunction

endpackage

// File: rtl/m_mem_arbiter_rr_if.sv
// Hart-side request buses and arbiter-side muxed outputs of the memory-port arbiter.
// The harts (or the bench) drive the master view; the arbiter takes the slave view.
interface m_mem_arbiter_rr_if #(
  parameter int N_HARTS = 2
) ();
  import m_mem_arbiter_rr_pkg::*;

  localparam int SW = sel_width(N_HARTS);

  logic [N_HARTS-1:0]       i_req;
  logic [N_HARTS-1:0]       i_boundary;
  logic [N_HARTS-1:0]       i_lock;
  logic [N_HARTS*XLEN-1:0]  i_iaddr;
  logic [N_HARTS*XLEN-1:0]  i_daddr;
  logic [N_HARTS*XLEN-1:0]  i_wdata;
  logic [N_HARTS*CTRLW-1:0] i_ctrl;
  logic [N_HARTS-1:0]       i_we;
  logic                     i_mem_busy;
  logic                     i_dram_busy;

  logic [N_HARTS-1:0]       o_grant;
  logic [SW-1:0]            o_sel;
  logic [XLEN-1:0]          o_iaddr;
  logic [XLEN-1:0]          o_daddr;
  logic [XLEN-1:0]          o_wdata;
  logic [CTRLW-1:0]         o_ctrl;
  logic                     o_we;
  logic [N_HARTS-1:0]       o_busy;
  logic [N_HARTS-1:0]       o_dram_busy;
  logic [1:0]               o_state;

  modport master (
    output i_req, i_boundary, i_lock, i_iaddr, i_daddr, i_wdata, i_ctrl, i_we,
           i_mem_busy, i_dram_busy,
    input  o_grant, o_sel, o_iaddr, o_daddr, o_wdata, o_ctrl, o_we, o_busy,
           o_dram_busy, o_state
  );

  modport slave (
    input  i_req, i_boundary, i_lock, i_iaddr, i_daddr, i_wdata, i_ctrl, i_we,
           i_mem_busy, i_dram_busy,
    output o_grant, o_sel, o_iaddr, o_daddr, o_wdata, o_ctrl, o_we, o_busy,
           o_dram_busy, o_state
  );

endinterface

// File: rtl/m_rr_pick.sv
// Combinational winner pick: rotating search starting after start_i, or lowest index
// first when mode_i is set.
module m_rr_pick #(
  parameter int N_HARTS = 2,
  parameter int SW      = 1
) (
  input  logic [N_HARTS-1:0] req_i,
  input  logic [SW-1:0]      start_i,
  input  logic               mode_i,
  output logic [SW-1:0]      win_o,
  output logic               valid_o
);

  int idx;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    win_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_HARTS; k++) begin
      idx = mode_i ? k : (int'(start_i) + 1 + k) % N_HARTS;
      if (!valid_o && req_i[idx]) begin
        win_o   = SW'(idx);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_mem_arbiter_rr.sv
// Memory-port arbiter: grants one hart at a time and hands over only at switch-safe points.
// After QUANTUM cycles of ownership, another requesting hart may take over.
module m_mem_arbiter_rr
  import m_mem_arbiter_rr_pkg::*;
#(
  parameter int N_HARTS = 2,
  parameter int QUANTUM = 64,
  parameter int MODE    = 0
) (
  input logic              CLK,
  input logic              RST_X,
  m_mem_arbiter_rr_if.slave bus
);

  localparam int SW = sel_width(N_HARTS);
  localparam int CW = $clog2(QUANTUM + 1);

  arb_state_e         state_q;
  logic [SW-1:0]      sel_q;
  logic [CW-1:0]      cnt_q;
  logic [N_HARTS-1:0] grant_q;

  logic [SW-1:0]      pick_idx;
  logic               pick_vld;
  logic [N_HARTS-1:0] sel_oh;
  logic               cnt_full;
  logic               others_req;
  logic               handover_ok;
  logic               own;
  logic [N_HARTS-1:0] busy_v;
  logic [N_HARTS-1:0] dbusy_v;

  m_rr_pick #(
    .N_HARTS (N_HARTS),
    .SW      (SW)
  ) u_pick (
    .req_i   (bus.i_req),
    .start_i (sel_q),
    .mode_i  (MODE == 1),
    .win_o   (pick_idx),
    .valid_o (pick_vld)
  );

  assign sel_oh      = N_HARTS'(1) << sel_q;
  assign cnt_full    = (cnt_q == CW'(QUANTUM));
  assign others_req  = |(bus.i_req & ~sel_oh);
  // Leave only at a safe point, and either the owner is done or its quantum is spent while others wait.
  assign handover_ok = bus.i_boundary[sel_q] & ~bus.i_lock[sel_q] & ~bus.i_mem_busy &
                       (~bus.i_req[sel_q] | (cnt_full & others_req));

  always_ff @(posedge CLK or negedge RST_X) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!RST_X) begin
      state_q <= ST_IDLE;
      sel_q   <= SW'(N_HARTS - 1);
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      case (state_q)
        ST_OWN: begin
          if (handover_ok) begin
            state_q <= ST_HANDOVER;
            grant_q <= '0;
          end else if (!cnt_full) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // Idle, handover and the unreachable encoding all regrant from a fresh pick.
        default: begin
          if (pick_vld) begin
            state_q <= ST_OWN;
            sel_q   <= pick_idx;
            cnt_q   <= '0;
            grant_q <= N_HARTS'(1) << pick_idx;
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign own = (state_q == ST_OWN);

  always_comb begin
    busy_v  = '1;
    dbusy_v = '1;
    if (own) begin
      busy_v[sel_q]  = bus.i_mem_busy;
      dbusy_v[sel_q] = bus.i_dram_busy;
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_sel       = sel_q;
  assign bus.o_state     = state_q;
  assign bus.o_busy      = busy_v;
  assign bus.o_dram_busy = dbusy_v;
  // Address and write-data buses follow the last owner even without a grant.
  assign bus.o_iaddr     = bus.i_iaddr[int'(sel_q)*XLEN +: XLEN];
  assign bus.o_daddr     = bus.i_daddr[int'(sel_q)*XLEN +: XLEN];
  assign bus.o_wdata     = bus.i_wdata[int'(sel_q)*XLEN +: XLEN];
  assign bus.o_ctrl      = own ? bus.i_ctrl[int'(sel_q)*CTRLW +: CTRLW] : '0;
  assign bus.o_we        = own & bus.i_we[sel_q];

endmodule

// File: doc/m_mem_arbiter_rr.md
M_MEM_ARBITER_RR -- requirements
Module: m_mem_arbiter_rr

Interface
REQ-001 SHALL have parameter N_HARTS, default 2, number of hart ports (1..16).
REQ-002 SHALL have parameter QUANTUM, default 64, minimum cycles of ownership before a fairness handover.
REQ-003 SHALL have parameter MODE, default 0; 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 CLK  in  1  single clock; all state updates on posedge.
REQ-005 RST_X  in  1  reset, asynchronous, active-low.
REQ-006 i_req  in  N_HARTS  hart requests memory-port ownership.
REQ-007 i_boundary  in  N_HARTS  hart at a switch-safe point: pipeline idle, no CSR op in EX/MEM, instruction taken.
REQ-008 i_lock  in  N_HARTS  hart inside an atomic sequence; handover forbidden.
REQ-009 i_iaddr, i_daddr, i_wdata  in  N_HARTS*32 each  flattened per-hart buses; hart g occupies bits [32g+31:32g].
REQ-010 i_ctrl  in  N_HARTS*3  per-hart data control; i_we  in  N_HARTS  per-hart write enable.
REQ-011 i_mem_busy, i_dram_busy  in  1 each  shared memory and DRAM busy.
REQ-012 o_grant  out  N_HARTS  one-hot (or zero) ownership.
REQ-013 o_sel  out  SW = max(1,$clog2(N_HARTS))  index of last/current owner.
REQ-014 o_iaddr, o_daddr, o_wdata  out  32 each; o_ctrl  out  3; o_we  out  1  muxed owner buses.
REQ-015 o_busy, o_dram_busy  out  N_HARTS each  per-hart busy views.
REQ-016 o_state  out  2  FSM state for debug.

Function
REQ-017 FSM states SHALL be IDLE=0, OWN=1, HANDOVER=2; encoding 3 unreachable, decoded as IDLE.
REQ-018 IDLE: o_grant=0; if any i_req, SHALL pick a winner, load o_sel and enter OWN next cycle (request at t -> grant visible at t+1).
REQ-019 Round-robin pick SHALL search indices o_sel+1, o_sel+2, ... modulo N_HARTS, o_sel itself last; first requester wins.
REQ-020 Fixed-priority pick (MODE=1) SHALL select the lowest-index requester.
REQ-021 OWN: o_grant[o_sel]=1; o_busy[o_sel]=i_mem_busy, o_dram_busy[o_sel]=i_dram_busy; all other bits 1.
REQ-022 OWN quantum counter (width $clog2(QUANTUM+1)) SHALL clear on entry to OWN, increment per cycle, saturate at QUANTUM.
REQ-023 OWN -> HANDOVER SHALL occur only when i_boundary[o_sel] & !i_lock[o_sel] & !i_mem_busy & (!i_req[o_sel] | (counter==QUANTUM & another hart requesting)).
REQ-024 Sole requester that keeps i_req SHALL retain ownership indefinitely; no needless handover.
REQ-025 i_lock SHALL override quantum expiry; i_req dropping while i_mem_busy=1 SHALL NOT leave OWN.
REQ-026 HANDOVER: exactly one cycle, o_grant=0, all busy bits 1; next cycle -> OWN with new pick, or IDLE if no request.
REQ-027 When o_grant=0: o_we=0, o_ctrl=0, address/wdata outputs SHALL hold hart o_sel's buses.
REQ-028 N_HARTS=1: SHALL behave identically, HANDOVER regrants hart 0 if still requesting.

Reset
REQ-029 RST_X low SHALL immediately force IDLE, o_sel=N_HARTS-1 (first round-robin pick starts at hart 0), counter=0, o_grant=0, o_we=0, o_ctrl=0, all o_busy/o_dram_busy=1.
REQ-030 Reset asserted mid-OWN SHALL abandon ownership with no completion cycle; first grant after release no earlier than one cycle after RST_X rises.

Structure
REQ-031 State encodings SHALL be defined in the shared define header next to the PRIV_* constants.
REQ-032 Rotating priority pick SHALL be one sub-module, m_rr_pick (inputs: request vector, start index, mode; output: winner index, valid); combinational only.

Verification
REQ-033 N=4, RR: reset, i_req=4'b1111, boundary every cycle, QUANTUM=4 -> grants 0,1,2,3,0 each after OWN of 5 cycles + 1 HANDOVER cycle.
REQ-034 N=4, i_req=4'b0100 only -> grant hart 2 at t+1, held 200 cycles, o_state never 2.
REQ-035 Owner hart 1 with i_lock=1, hart 3 requesting, counter saturated -> no handover until lock drops and boundary=1; then grant hart 3 two cycles later.
REQ-036 Owner drops i_req while i_mem_busy=1 for 10 cycles -> stays OWN, o_busy[owner]=1 tracks i_mem_busy, HANDOVER first cycle after busy low & boundary.
REQ-037 MODE=1, i_req=4'b1010 simultaneously from IDLE -> hart 1 granted; all non-owner o_busy bits=1 every cycle.
REQ-038 RST_X pulsed low mid-OWN (asynchronous, between edges) -> o_grant=0 and o_state=0 before the next edge; after release, i_req=4'b1111 grants hart 0.
